// File: rtl/vec_mem_sequencer_if.sv
// Bundle of the vector request, I/O arbitration and data-memory port signals.
// The master side is the requester/memory environment; the slave side is the sequencer.
interface vec_mem_sequencer_if #(
  parameter int DW    = 24,
  parameter int AW    = 24,
  parameter int LANES = 4,
  parameter int LW    = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [AW-1:0]         req_base;
  logic [LW-1:0]         req_len;
  logic [LANES*DW-1:0]   req_wdata;
  logic                  done;
  logic [LANES*DW-1:0]   rdata;
  logic                  io_req;
  logic                  io_grant;
  logic                  mem_we;
  logic [AW-1:0]         mem_a;
  logic [DW-1:0]         mem_wd;
  logic [DW-1:0]         mem_rd;
  logic                  mem_startIO;

  modport master (
    output req_valid, req_we, req_base, req_len, req_wdata, io_req, mem_rd,
    input  req_ready, done, rdata, io_grant, mem_we, mem_a, mem_wd, mem_startIO
  );

  modport slave (
    input  req_valid, req_we, req_base, req_len, req_wdata, io_req, mem_rd,
    output req_ready, done, rdata, io_grant, mem_we, mem_a, mem_wd, mem_startIO
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer for the single-port data memory: one element per cycle
// at consecutive addresses, load lanes captured into rdata, I/O dump granted only when idle.
module vec_mem_sequencer #(
  parameter int DW    = 24,
  parameter int AW    = 24,
  parameter int LANES = 4,
  parameter int LW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  vec_mem_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_IO     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [LW-1:0]         len_q, len_d;
  logic                  we_q, we_d;
  logic [LANES*DW-1:0]   wdata_q, wdata_d;
  logic [LANES*DW-1:0]   rdata_q, rdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  done_q, done_d;
  logic                  io_grant_q, io_grant_d;
  logic                  mem_we_q, mem_we_d;
  logic [AW-1:0]         mem_a_q, mem_a_d;
  logic [DW-1:0]         mem_wd_q, mem_wd_d;
  logic [LW-1:0]         len_clamped_s;

  function automatic logic [DW-1:0] get_lane(input logic [LANES*DW-1:0] d,
                                             input logic [LW-1:0]       idx);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      r = (idx == LW'(i)) ? d[i*DW +: DW] : r;
    end
    return r;
  endfunction

  assign len_clamped_s = (bus.req_len > LW'(LANES)) ? LW'(LANES) : bus.req_len;

  // Next-state and next-output computation; memory outputs are zero unless the next cycle is an access.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    mem_we_d = 1'b0;
    mem_a_d  = '0;
    mem_wd_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          len_d   = len_clamped_s;
          cnt_d   = '0;
          if (len_clamped_s == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_ACCESS;
            mem_we_d = bus.req_we;
            mem_a_d  = bus.req_base;
            mem_wd_d = get_lane(bus.req_wdata, '0);
          end
        end else if (bus.io_req) begin
          state_d = ST_IO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        for (int i = 0; i < LANES; i++) begin
          if (!we_q && (cnt_q == LW'(i))) begin
            rdata_d[i*DW +: DW] = bus.mem_rd;
          end else begin
            rdata_d[i*DW +: DW] = rdata_q[i*DW +: DW];
          end
        end
        if (cnt_q == (len_q - LW'(1))) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d    = cnt_q + LW'(1);
          mem_we_d = we_q;
          mem_a_d  = mem_a_q + AW'(1);
          mem_wd_d = get_lane(wdata_q, cnt_q + LW'(1));
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_IO: begin
        if (bus.io_req) begin
          state_d = ST_IO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_ready_d = (state_d == ST_IDLE);
    io_grant_d  = (state_d == ST_IO);
  end

  // State and registered outputs; reset aborts any transfer and clears rdata.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b0;
      done_q      <= 1'b0;
      io_grant_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_a_q     <= '0;
      mem_wd_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      io_grant_q  <= io_grant_d;
      mem_we_q    <= mem_we_d;
      mem_a_q     <= mem_a_d;
      mem_wd_q    <= mem_wd_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.io_grant    = io_grant_q;
  assign bus.mem_startIO = io_grant_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_a       = mem_a_q;
  assign bus.mem_wd      = mem_wd_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Scoreboard bench for vec_mem_sequencer: expected writes and completion rdata are queued
// when a request is driven and compared when the sequencer writes memory or pulses done.
module tb_vec_mem_sequencer;
  localparam int DW    = 24;
  localparam int AW    = 24;
  localparam int LANES = 4;
  localparam int LW    = 3;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  logic [DW-1:0]       mem_arr     [0:63];
  logic [DW-1:0]       model_mem   [0:63];
  logic [LANES*DW-1:0] model_rdata;
  wr_t                 exp_wr[$];
  logic [LANES*DW-1:0] exp_done[$];
  logic                prev_done;

  vec_mem_sequencer_if #(.DW(DW), .AW(AW), .LANES(LANES), .LW(LW)) bus();

  vec_mem_sequencer #(.DW(DW), .AW(AW), .LANES(LANES), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rd = mem_arr[bus.mem_a[5:0]];

  always @(posedge clk) begin
    if (bus.mem_we) mem_arr[bus.mem_a[5:0]] <= bus.mem_wd;
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write scoreboard, done/rdata scoreboard and startIO tracking
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_we) begin
      if (exp_wr.size() == 0) begin
        check_eq("unexpected_write", {104'd0, bus.mem_a}, 128'h1_000000);
      end else begin
        e = exp_wr.pop_front();
        check_eq("wr_addr", {104'd0, bus.mem_a}, {104'd0, e.addr});
        check_eq("wr_data", {104'd0, bus.mem_wd}, {104'd0, e.data});
      end
    end
    if (bus.done) begin
      check_eq("done_width", {127'd0, prev_done}, 128'd0);
      if (exp_done.size() == 0) begin
        check_eq("unexpected_done", 128'd1, 128'd0);
      end else begin
        check_eq("rdata", {32'd0, bus.rdata}, {32'd0, exp_done.pop_front()});
      end
    end
    if (bus.mem_startIO !== bus.io_grant) begin
      check_eq("startio_eq_grant", {127'd0, bus.mem_startIO}, {127'd0, bus.io_grant});
    end
    prev_done <= bus.done;
  end

  task automatic issue_req(input logic we, input logic [AW-1:0] base, input logic [LW-1:0] len,
                           input logic [LANES*DW-1:0] wdata, input logic io_with);
    int            elen;
    int            n;
    logic          seen;
    logic [AW-1:0] a;
    elen = (len > LW'(LANES)) ? LANES : int'(len);
    @(negedge clk);
    check_eq("ready_before_req", {127'd0, bus.req_ready}, 128'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_base  = base;
    bus.req_len   = len;
    bus.req_wdata = wdata;
    bus.io_req    = io_with;
    for (int k = 0; k < elen; k++) begin
      a = base + AW'(k);
      if (we) begin
        exp_wr.push_back('{addr: a, data: wdata[k*DW +: DW]});
        model_mem[a[5:0]] = wdata[k*DW +: DW];
      end else begin
        model_rdata[k*DW +: DW] = model_mem[a[5:0]];
      end
    end
    exp_done.push_back(model_rdata);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_base  = AW'($urandom);
    bus.req_len   = LW'($urandom_range(0, 7));
    bus.req_wdata = '1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = bus.done;
    end
    check_eq("done_latency", 128'(n), 128'(elen + 1));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    prev_done = 1'b0;
    model_rdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem_arr[i]   = '0;
      model_mem[i] = '0;
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_base  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    bus.io_req    = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_ready",   {127'd0, bus.req_ready},   128'd0);
    check_eq("rst_done",    {127'd0, bus.done},        128'd0);
    check_eq("rst_grant",   {127'd0, bus.io_grant},    128'd0);
    check_eq("rst_startio", {127'd0, bus.mem_startIO}, 128'd0);
    check_eq("rst_we",      {127'd0, bus.mem_we},      128'd0);
    check_eq("rst_a",       {104'd0, bus.mem_a},       128'd0);
    check_eq("rst_wd",      {104'd0, bus.mem_wd},      128'd0);
    check_eq("rst_rdata",   {32'd0, bus.rdata},        128'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", {127'd0, bus.req_ready}, 128'd1);

    // basic store, load-back, wrapping store
    issue_req(1'b1, 24'd24, 3'd4, {24'h444444, 24'h333333, 24'h222222, 24'h111111}, 1'b0);
    issue_req(1'b0, 24'd24, 3'd4, '0, 1'b0);
    issue_req(1'b1, 24'hFFFFFE, 3'd4, {24'hD4D4D4, 24'hC3C3C3, 24'hB2B2B2, 24'hA1A1A1}, 1'b0);
    issue_req(1'b0, 24'hFFFFFE, 3'd4, '0, 1'b0);

    // length boundaries, back-to-back
    issue_req(1'b1, 24'd30, 3'd0, {24'h0F0F0F, 24'h0E0E0E, 24'h0D0D0D, 24'h0C0C0C}, 1'b0);
    issue_req(1'b1, 24'd32, 3'd7, {24'h987654, 24'h876543, 24'h765432, 24'h654321}, 1'b0);
    issue_req(1'b0, 24'd32, 3'd7, '0, 1'b0);
    issue_req(1'b0, 24'hFFFFFE, 3'd2, '0, 1'b0);
    issue_req(1'b0, 24'd24, 3'd0, '0, 1'b0);

    // vector request and io_req together
    issue_req(1'b0, 24'd24, 3'd2, '0, 1'b1);
    @(negedge clk);
    check_eq("io_idle_grant", {127'd0, bus.io_grant},  128'd0);
    check_eq("io_idle_ready", {127'd0, bus.req_ready}, 128'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("io_grant",   {127'd0, bus.io_grant},    128'd1);
      check_eq("io_startio", {127'd0, bus.mem_startIO}, 128'd1);
      check_eq("io_ready",   {127'd0, bus.req_ready},   128'd0);
    end
    bus.io_req = 1'b0;
    @(negedge clk);
    check_eq("io_release_grant", {127'd0, bus.io_grant},  128'd0);
    check_eq("io_release_ready", {127'd0, bus.req_ready}, 128'd1);

    // reset during the third access of a store
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_base  = 24'd40;
    bus.req_len   = 3'd4;
    bus.req_wdata = {24'h5A5A5A, 24'h4B4B4B, 24'h3C3C3C, 24'h2D2D2D};
    exp_wr.push_back('{addr: 24'd40, data: 24'h2D2D2D});
    exp_wr.push_back('{addr: 24'd41, data: 24'h3C3C3C});
    exp_wr.push_back('{addr: 24'd42, data: 24'h4B4B4B});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_we",    {127'd0, bus.mem_we},    128'd0);
    check_eq("abort_a",     {104'd0, bus.mem_a},     128'd0);
    check_eq("abort_done",  {127'd0, bus.done},      128'd0);
    check_eq("abort_rdata", {32'd0, bus.rdata},      128'd0);
    check_eq("abort_ready", {127'd0, bus.req_ready}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready_after", {127'd0, bus.req_ready}, 128'd1);
    repeat (6) @(negedge clk);
    check_eq("abort_base3_unwritten", {104'd0, mem_arr[43]}, 128'd0);
    check_eq("wr_queue_empty",   128'(exp_wr.size()),   128'd0);
    check_eq("done_queue_empty", 128'(exp_done.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
